// File: rtl/apb_fifo_periph.sv
// apb_fifo_periph: APB slave FIFO mailbox with exactly one wait state per transfer.
// Optional macro FIFO_IRQ_EN adds the IER register and a registered irq output.
module apb_fifo_periph #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
`ifdef FIFO_IRQ_EN
  output logic        irq,
`endif
  output logic        PREADY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] A_FSR  = 3'd0;
  localparam logic [2:0] A_FWD  = 3'd1;
  localparam logic [2:0] A_FRD  = 3'd2;
  localparam logic [2:0] A_CTRL = 3'd3;

  logic              pready_q, pready_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [2:0]  sel;
  logic        commit, do_push, do_pop, do_ctrl, empty, full;
  logic [31:0] fsr, head_ext, rd_word;
  logic        unused_addr;

  assign sel         = PADDR[4:2];
  assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};
  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == FULL_CNT);

  // Side effects land only on the edge that ends the PREADY=1 access cycle.
  assign commit  = PSEL & PENABLE & pready_q;
  assign do_push = commit &  PWRITE & (sel == A_FWD);
  assign do_pop  = commit & ~PWRITE & (sel == A_FRD);
  assign do_ctrl = commit &  PWRITE & (sel == A_CTRL);

  assign fsr = {16'd0, 8'(cnt_q), 4'd0, udf_q, ovf_q, full, empty};

  always_comb begin
    pready_d = PSEL & PENABLE & ~pready_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (do_push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
      end
    end
    if (do_pop) begin
      if (empty) begin
        udf_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d    = cnt_q - 1'b1;
      end
    end
    if (do_ctrl) begin
      if (PWDATA[0]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
      end
      if (PWDATA[2]) ovf_d = 1'b0;
      if (PWDATA[3]) udf_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pready_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      pready_q <= pready_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage needs no reset: count/pointers define which entries are live.
  always_ff @(posedge PCLK) begin
    if (do_push && !full) mem_q[wr_ptr_q] <= PWDATA[DATA_W-1:0];
  end

`ifdef FIFO_IRQ_EN
  localparam logic [2:0] A_IER = 3'd4;

  logic [1:0] ier_q, ier_d;
  logic       irq_q;

  assign ier_d = (commit && PWRITE && sel == A_IER) ? PWDATA[1:0] : ier_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ier_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ier_q <= ier_d;
      irq_q <= (ier_q[0] & ~empty) | (ier_q[1] & (ovf_q | udf_q));
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    head_ext = '0;
    head_ext[DATA_W-1:0] = mem_q[rd_ptr_q];
    rd_word = '0;
    case (sel)
      A_FSR:   rd_word = fsr;
      A_FRD:   rd_word = empty ? '0 : head_ext;
`ifdef FIFO_IRQ_EN
      A_IER:   rd_word = {30'd0, ier_q};
`endif
      default: rd_word = '0;
    endcase
  end

  assign PRDATA = pready_q ? rd_word : '0;
  assign PREADY = pready_q;

endmodule

// File: tb/tb_apb_fifo_periph.sv
// Bench for apb_fifo_periph: directed scenarios plus randomized traffic against a queue-based model.
module tb_apb_fifo_periph;
  localparam int DEPTH = 8;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic        PWRITE = 1'b0, PENABLE = 1'b0, PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
`ifdef FIFO_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_ovf, m_udf;
  logic [1:0]  m_ier;

  apb_fifo_periph #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
`ifdef FIFO_IRQ_EN
    .irq(irq),
`endif
    .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_fsr();
    return {16'd0, 8'(mq.size()), 4'd0, m_udf, m_ovf, mq.size() == DEPTH, mq.size() == 0};
  endfunction

  function automatic logic exp_irq();
    return (m_ier[0] && mq.size() != 0) || (m_ier[1] && (m_ovf || m_udf));
  endfunction

  function automatic void model_reset();
    mq.delete(); m_ovf = 0; m_udf = 0; m_ier = '0;
  endfunction

  function automatic void model_push(input logic [31:0] d);
    if (mq.size() == DEPTH) m_ovf = 1; else mq.push_back(d);
  endfunction

  function automatic logic [31:0] model_pop();
    if (mq.size() == 0) begin m_udf = 1; return 32'd0; end
    return mq.pop_front();
  endfunction

  function automatic void model_ctrl(input logic [31:0] v);
    if (v[0]) mq.delete();
    if (v[2]) m_ovf = 0;
    if (v[3]) m_udf = 0;
  endfunction

  // One complete APB transfer; reports read data, PREADY latency after PENABLE,
  // and whether PREADY was low before and after its single high cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat, output logic shp);
    logic early, seen;
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(negedge PCLK);
    early = PREADY; PENABLE = 1;
    lat = 0; seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge PCLK); lat++; seen = PREADY;
    end
    if (!seen) lat = 99;
    rd = PRDATA;
    @(negedge PCLK);
    shp = !early && !PREADY;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat; logic shp;
    PRESET = 1;
    repeat (2) @(negedge PCLK);
    total++; if (PREADY !== 1'b0 || PRDATA !== 32'd0) begin
      bad++; $display("FAIL t1_por got PREADY=%b PRDATA=%h exp 0/0", PREADY, PRDATA); end
    PRESET = 0; model_reset();
    xfer(1, 32'h04, 32'h55, rd, lat, shp); model_push(32'h55);
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h04; PWDATA = 32'h66;
    @(negedge PCLK); PENABLE = 1;
    @(negedge PCLK);
    total++; if (PREADY !== 1'b1) begin
      bad++; $display("FAIL t1_ready_pre got=%b exp=1", PREADY); end
    #1 PRESET = 1; #1;
    total++; if (PREADY !== 1'b0 || PRDATA !== 32'd0) begin
      bad++; $display("FAIL t1_abort got PREADY=%b PRDATA=%h exp 0/0", PREADY, PRDATA); end
    PSEL = 0; PENABLE = 0; model_reset();
    @(negedge PCLK); PRESET = 0;
    xfer(0, 32'h00, 0, rd, lat, shp);
    total++; if (rd !== 32'h1) begin
      bad++; $display("FAIL t1_fsr got=%h exp=00000001", rd); end
  endtask

  task automatic test_fifo();
    logic [31:0] rd, e; int lat; logic shp;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 32'h04, 32'(10 + i), rd, lat, shp); model_push(32'(10 + i));
      total++; if (lat !== 1 || !shp) begin
        bad++; $display("FAIL t2_push_hs%0d got lat=%0d shape=%b exp lat=1 shape=1", i, lat, shp); end
    end
    for (int i = 0; i < 4; i++) begin
      xfer(0, 32'h08, 0, rd, lat, shp); e = model_pop();
      total++; if (rd !== 32'(10 + i) || rd !== e) begin
        bad++; $display("FAIL t2_pop%0d got=%h exp=%h", i, rd, 32'(10 + i)); end
      total++; if (lat !== 1 || !shp) begin
        bad++; $display("FAIL t2_pop_hs%0d got lat=%0d shape=%b exp lat=1 shape=1", i, lat, shp); end
    end
    xfer(0, 32'h00, 0, rd, lat, shp);
    total++; if (rd !== 32'h1) begin
      bad++; $display("FAIL t2_fsr got=%h exp=00000001", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, e; int lat; logic shp;
    for (int i = 1; i <= 9; i++) begin
      xfer(1, 32'h04, 32'(i), rd, lat, shp); model_push(32'(i));
    end
    xfer(0, 32'h00, 0, rd, lat, shp);
    total++; if (rd !== 32'h0806) begin
      bad++; $display("FAIL t3_fsr got=%h exp=00000806", rd); end
    for (int i = 1; i <= 8; i++) begin
      xfer(0, 32'h08, 0, rd, lat, shp); e = model_pop();
      total++; if (rd !== 32'(i) || rd !== e) begin
        bad++; $display("FAIL t3_pop%0d got=%h exp=%h", i, rd, 32'(i)); end
    end
    xfer(1, 32'h0C, 32'h4, rd, lat, shp); model_ctrl(32'h4);
  endtask

  task automatic test_underflow();
    logic [31:0] rd, e; int lat; logic shp;
    xfer(0, 32'h08, 0, rd, lat, shp); e = model_pop();
    total++; if (rd !== 32'd0) begin
      bad++; $display("FAIL t4_pop_empty got=%h exp=00000000", rd); end
    xfer(0, 32'h00, 0, rd, lat, shp);
    total++; if (rd !== 32'h9 || rd !== exp_fsr()) begin
      bad++; $display("FAIL t4_fsr_udf got=%h exp=00000009", rd); end
    xfer(1, 32'h0C, 32'h8, rd, lat, shp); model_ctrl(32'h8);
    xfer(0, 32'h00, 0, rd, lat, shp);
    total++; if (rd !== 32'h1) begin
      bad++; $display("FAIL t4_fsr_clr got=%h exp=00000001", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, e; int lat; logic shp;
    for (int i = 0; i < 6; i++) begin
      xfer(1, 32'h04, 32'(i), rd, lat, shp); model_push(32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      xfer(0, 32'h08, 0, rd, lat, shp); e = model_pop();
    end
    for (int i = 0; i < 5; i++) begin
      xfer(1, 32'h04, 32'hA0 + 32'(i), rd, lat, shp); model_push(32'hA0 + 32'(i));
    end
    xfer(0, 32'h00, 0, rd, lat, shp);
    total++; if (rd !== 32'h0500) begin
      bad++; $display("FAIL t5_fsr_cnt got=%h exp=00000500", rd); end
    for (int i = 0; i < 5; i++) begin
      xfer(0, 32'h08, 0, rd, lat, shp); e = model_pop();
      total++; if (rd !== 32'hA0 + 32'(i) || rd !== e) begin
        bad++; $display("FAIL t5_pop%0d got=%h exp=%h", i, rd, 32'hA0 + 32'(i)); end
    end
    xfer(1, 32'h04, 32'hBEEF, rd, lat, shp); model_push(32'hBEEF);
    xfer(1, 32'h0C, 32'h1, rd, lat, shp); model_ctrl(32'h1);
    xfer(0, 32'h00, 0, rd, lat, shp);
    total++; if (rd !== 32'h1) begin
      bad++; $display("FAIL t5_flush got=%h exp=00000001", rd); end
  endtask

  task automatic test_psel_abort();
    logic [31:0] rd; int lat; logic shp;
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h04; PWDATA = 32'h1234;
    @(negedge PCLK); PENABLE = 1;
    @(negedge PCLK); PSEL = 0; PENABLE = 0;
    @(negedge PCLK);
    total++; if (PREADY !== 1'b0) begin
      bad++; $display("FAIL abort_ready got=%b exp=0", PREADY); end
    xfer(0, 32'h00, 0, rd, lat, shp);
    total++; if (rd !== exp_fsr()) begin
      bad++; $display("FAIL abort_fsr got=%h exp=%h", rd, exp_fsr()); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd, e; int lat; logic shp;
    xfer(1, 32'h04, 32'h42, rd, lat, shp); model_push(32'h42);
    xfer(1, 32'h1C, 32'hFFFF_FFFF, rd, lat, shp);
    xfer(1, 32'h00, 32'hFFFF_FFFF, rd, lat, shp);
    xfer(1, 32'h08, 32'hFFFF_FFFF, rd, lat, shp);
    xfer(0, 32'h00, 0, rd, lat, shp);
    total++; if (rd !== exp_fsr()) begin
      bad++; $display("FAIL unmap_fsr got=%h exp=%h", rd, exp_fsr()); end
    xfer(0, 32'h1C, 0, rd, lat, shp);
    total++; if (rd !== 32'd0) begin
      bad++; $display("FAIL unmap_rd1c got=%h exp=00000000", rd); end
    xfer(0, 32'h04, 0, rd, lat, shp);
    total++; if (rd !== 32'd0) begin
      bad++; $display("FAIL unmap_rdfwd got=%h exp=00000000", rd); end
    xfer(0, 32'h0C, 0, rd, lat, shp);
    total++; if (rd !== 32'd0) begin
      bad++; $display("FAIL unmap_rdctrl got=%h exp=00000000", rd); end
    xfer(1, 32'h10, 32'h2, rd, lat, shp);
`ifdef FIFO_IRQ_EN
    m_ier = 2'h2;
`endif
    xfer(0, 32'h10, 0, rd, lat, shp);
    total++; if (rd !== {30'd0, m_ier}) begin
      bad++; $display("FAIL unmap_ier got=%h exp=%h", rd, {30'd0, m_ier}); end
    xfer(1, 32'h10, 32'h0, rd, lat, shp); m_ier = '0;
    xfer(0, 32'h08, 0, rd, lat, shp); e = model_pop();
  endtask

  task automatic test_irq();
`ifdef FIFO_IRQ_EN
    logic [31:0] rd, e; int lat; logic shp;
    xfer(1, 32'h10, 32'h1, rd, lat, shp); m_ier = 2'h1;
    xfer(1, 32'h04, 32'h77, rd, lat, shp); model_push(32'h77);
    total++; if (irq !== 1'b0) begin
      bad++; $display("FAIL t6_irq_early got=%b exp=0", irq); end
    @(negedge PCLK);
    total++; if (irq !== 1'b1) begin
      bad++; $display("FAIL t6_irq_set got=%b exp=1", irq); end
    xfer(0, 32'h08, 0, rd, lat, shp); e = model_pop();
    @(negedge PCLK);
    total++; if (irq !== 1'b0) begin
      bad++; $display("FAIL t6_irq_clr got=%b exp=0", irq); end
    xfer(1, 32'h10, 32'h2, rd, lat, shp); m_ier = 2'h2;
    xfer(0, 32'h08, 0, rd, lat, shp); e = model_pop();
    @(negedge PCLK);
    total++; if (irq !== 1'b1) begin
      bad++; $display("FAIL t6_irq_err got=%b exp=1", irq); end
    xfer(1, 32'h0C, 32'h8, rd, lat, shp); model_ctrl(32'h8);
    @(negedge PCLK);
    total++; if (irq !== 1'b0) begin
      bad++; $display("FAIL t6_irq_errclr got=%b exp=0", irq); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, e, d, hi; int lat; logic shp; int r;
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 9);
      // Undecoded address bits are randomized to show only PADDR[4:2] matters.
      hi = ($urandom & 32'hFFFF_FFE0) | ($urandom & 32'h3);
      if (r <= 3) begin
        d = $urandom;
        xfer(1, hi | 32'h04, d, rd, lat, shp); model_push(d);
      end else if (r <= 6) begin
        xfer(0, hi | 32'h08, 0, rd, lat, shp); e = model_pop();
        total++; if (rd !== e) begin
          bad++; $display("FAIL rnd_pop%0d got=%h exp=%h", n, rd, e); end
      end else if (r == 7) begin
        xfer(0, hi | 32'h00, 0, rd, lat, shp); e = exp_fsr();
        total++; if (rd !== e) begin
          bad++; $display("FAIL rnd_fsr%0d got=%h exp=%h", n, rd, e); end
      end else if (r == 8) begin
        d = $urandom & 32'hC;
        if ($urandom_range(0, 3) == 0) d[0] = 1'b1;
        xfer(1, hi | 32'h0C, d, rd, lat, shp); model_ctrl(d);
      end else begin
        d = 32'($urandom_range(0, 3));
        xfer(1, hi | 32'h10, d, rd, lat, shp);
`ifdef FIFO_IRQ_EN
        m_ier = d[1:0];
`endif
      end
      total++; if (lat !== 1 || !shp) begin
        bad++; $display("FAIL rnd_hs%0d got lat=%0d shape=%b exp lat=1 shape=1", n, lat, shp); end
`ifdef FIFO_IRQ_EN
      @(negedge PCLK);
      total++; if (irq !== exp_irq()) begin
        bad++; $display("FAIL rnd_irq%0d got=%b exp=%b", n, irq, exp_irq()); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fifo();
    test_overflow();
    test_underflow();
    test_wrap();
    test_irq();
    test_psel_abort();
    test_unmapped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
